nabp_swappable: RTL and testbench
=================================

Name: nabp_swappable

Overview:
- One of the two ping-pong swappable line buffers driven by the NABP swap controller; this block is the responder side of the swap protocol.
- Fill phase: loads BUF_DEPTH sinogram samples from memory. Read addresses come from a fixed-point map accumulator, and asserts swap_ready when the load is complete.
- Shift phase, entered on swap: streams the buffer to the processing elements under a fractional shift accumulator, then requests the next iteration.

Parameters:
DATA_W, 12, sinogram sample width
ADDR_W, 10, sinogram memory address width
ACCU_W, 14, map accumulator width, unsigned fixed point
FRAC_W, 4, fractional bits in both accumulators
BUF_DEPTH, 8, samples loaded per fill
SHIFT_LEN, 16, pe_en cycles per shift phase

Ports:
clk  in  1  clock
reset_n  in  1  reset, synchronous, active-low
mp_accu_init  in  ACCU_W  map accumulator start value, latched on accepted next_itr_ack
mp_accu_base  in  ACCU_W  map accumulator increment, latched with mp_accu_init
sh_accu_base  in  FRAC_W+1  shift increment, latched on accepted swap
swap  in  1  1-cycle pulse from controller: begin shift
next_itr_ack  in  1  1-cycle pulse from controller: start the next fill
swap_ready  out  1  fill complete, buffer valid
next_itr  out  1  shift complete, requesting the next iteration
mem_rd  out  1  sinogram read strobe
mem_addr  out  ADDR_W  sinogram read address
mem_data  in  DATA_W  read data, valid exactly 1 cycle after mem_rd
pe_kick  out  1  pulse on the first shift cycle
pe_en  out  1  PE enable during shift
pe_data  out  DATA_W  buffer head, buf[0]

Behaviour:
- Reset values: state idle_s, all outputs 0, buffer and accumulators 0. Reset mid-operation aborts immediately and discards any in-flight read.
- States and transitions:
  - idle_s: on next_itr_ack, latch mp_accu_init and mp_accu_base, set accu = init, go to fill_s.
  - fill_s: issue reads k = 0..BUF_DEPTH-1 on consecutive cycles. mem_addr = accu[ACCU_W-1:FRAC_W] truncated to ADDR_W. After each read, accu += base, modulo 2^ACCU_W. mem_data is written to buf[k] on the following cycle. The cycle after the last capture goes to ready_s. Fill takes BUF_DEPTH+1 cycles; mem_rd is high for exactly BUF_DEPTH cycles.
  - ready_s: swap_ready = 1 (registered). On swap, latch sh_accu_base, clear sh_frac, go to shift_s.
  - shift_s: pe_en = 1 for exactly SHIFT_LEN cycles; pe_kick = 1 on the first of these only.
    - Each cycle: sum = sh_frac + base. A step occurs if sum ≥ 2^FRAC_W; sh_frac takes sum mod 2^FRAC_W.
    - Base ≥ 2^FRAC_W steps every cycle; at most one step per cycle.
    - Step: buffer shifts toward buf[0], and buf[BUF_DEPTH-1] takes 0. The new head is visible on pe_data the next cycle.
    - After SHIFT_LEN cycles, go to done_s.
  - done_s: next_itr = 1, held. On next_itr_ack: latch the new mp parameters, go to fill_s (the pulse is consumed, not re-sampled). Stay in done_s otherwise.
- Ignored events:
  - swap in any state other than ready_s.
  - next_itr_ack in fill_s, ready_s or shift_s.
  - Simultaneous swap and next_itr_ack: only the one legal in the current state acts.
- Zero-delay restart: a next_itr_ack in done_s gives mem_rd on the next cycle.

Optional Feature:
- Macro NABP_SWAPPABLE_PROTO_CHECK_EN.
- When defined: adds output proto_err (1 bit), sticky-high from the cycle after any ignored swap or next_itr_ack, or after swap and next_itr_ack in the same cycle. Cleared only by reset.
- When undefined: the port is absent and ignored events are silently dropped. Behaviour is otherwise identical.

Test Plan:
- Fill addressing: ack with init=0x020, base=0x018 -> mem_addr 2,3,5,6,8,9,11,12 on 8 consecutive cycles, each returning data = addr+100 -> swap_ready rises 9 cycles after fill entry, with buf = 102..112.
- Full-rate shift: swap with sh_accu_base=0x10 -> pe_kick on cycle 1, pe_en 16 cycles, pe_data 102,103,105,106,108,109,111,112 then 0 × 8 -> next_itr high.
- Half-rate shift: sh_accu_base=0x08 -> each sample held for 2 cycles; 102,102,103,103 … 112,112 over 16 cycles.
- Handshake: next_itr held 10 cycles until ack -> next_itr drops, mem_rd on the next cycle, new init latched. Ack a second time during fill -> ignored; proto_err=1 when the macro is defined.
- Illegal swap: swap pulse during fill_s -> no state change, fill completes normally; swap_ready only after the fill.
- Reset mid-shift at cycle 5 -> all outputs 0 next cycle, state idle_s; a subsequent ack restarts a clean fill.

Source files
------------

// File: rtl/nabp_swappable.sv
// rtl/nabp_swappable.sv - NABP ping-pong line buffer, responder side of the swap handshake.
// Optional NABP_SWAPPABLE_PROTO_CHECK_EN adds a sticky proto_err output for dropped events.
module nabp_swappable #(
   parameter int DATA_W    = 12,
   parameter int ADDR_W    = 10,
   parameter int ACCU_W    = 14,
   parameter int FRAC_W    = 4,
   parameter int BUF_DEPTH = 8,
   parameter int SHIFT_LEN = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ACCU_W-1:0] mp_accu_init,
   input  logic [ACCU_W-1:0] mp_accu_base,
   input  logic [FRAC_W:0]   sh_accu_base,
   input  logic              swap,
   input  logic              next_itr_ack,
   output logic              swap_ready,
   output logic              next_itr,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_data,
   output logic              pe_kick,
   output logic              pe_en,
   output logic [DATA_W-1:0] pe_data
`ifdef NABP_SWAPPABLE_PROTO_CHECK_EN
   ,
   output logic              proto_err
`endif
);

   localparam int CNT_W = $clog2(BUF_DEPTH + 1);
   localparam int IDX_W = $clog2(BUF_DEPTH);
   localparam int SH_W  = $clog2(SHIFT_LEN);
   localparam int INT_W = ACCU_W - FRAC_W;

   typedef enum logic [2:0] {idle_s, fill_s, ready_s, shift_s, done_s} state_t;

   state_t             state;
   state_t             state_nxt;
   logic [ACCU_W-1:0]  accu;
   logic [ACCU_W-1:0]  mp_base;
   logic [CNT_W-1:0]   fill_cnt;
   logic               rd_pend;
   logic [IDX_W-1:0]   rd_idx;
   logic [FRAC_W:0]    sh_base;
   logic [FRAC_W-1:0]  sh_frac;
   logic [SH_W-1:0]    sh_cnt;
   logic [DATA_W-1:0]  line_buf [BUF_DEPTH];
   logic [FRAC_W+1:0]  sh_sum;
   logic               sh_step;
   logic [INT_W-1:0]   accu_int;

   // One extra sum bit so base values >= 2^FRAC_W still produce a single step.
   assign sh_sum   = {2'b00, sh_frac} + {1'b0, sh_base};
   assign sh_step  = |sh_sum[FRAC_W+1:FRAC_W];
   assign accu_int = accu[ACCU_W-1:FRAC_W];

   always_ff @(posedge clk) begin
      if (!reset_n) state <= idle_s;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         idle_s:  if (next_itr_ack) state_nxt = fill_s;
         fill_s:  if (fill_cnt == CNT_W'(BUF_DEPTH)) state_nxt = ready_s;
         ready_s: if (swap) state_nxt = shift_s;
         shift_s: if (sh_cnt == SH_W'(SHIFT_LEN - 1)) state_nxt = done_s;
         done_s:  if (next_itr_ack) state_nxt = fill_s;
         default: state_nxt = idle_s;
      endcase
   end

   always_comb begin
      swap_ready = 1'b0;
      next_itr   = 1'b0;
      mem_rd     = 1'b0;
      mem_addr   = '0;
      pe_kick    = 1'b0;
      pe_en      = 1'b0;
      pe_data    = line_buf[0];
      case (state)
         ready_s: swap_ready = 1'b1;
         done_s:  next_itr = 1'b1;
         fill_s: begin
            mem_rd = (fill_cnt < CNT_W'(BUF_DEPTH));
            if (mem_rd) mem_addr = ADDR_W'(accu_int);
         end
         shift_s: begin
            pe_en   = 1'b1;
            pe_kick = (sh_cnt == '0);
         end
         default: ;
      endcase
   end

   // Read data lands one cycle after its strobe, so the slot index travels with rd_pend.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         accu     <= '0;
         mp_base  <= '0;
         fill_cnt <= '0;
         rd_pend  <= 1'b0;
         rd_idx   <= '0;
         sh_base  <= '0;
         sh_frac  <= '0;
         sh_cnt   <= '0;
         for (int i = 0; i < BUF_DEPTH; i++) line_buf[i] <= '0;
      end else begin
         rd_pend <= mem_rd;
         rd_idx  <= fill_cnt[IDX_W-1:0];
         if (rd_pend) line_buf[rd_idx] <= mem_data;
         case (state)
            idle_s, done_s: begin
               if (next_itr_ack) begin
                  accu     <= mp_accu_init;
                  mp_base  <= mp_accu_base;
                  fill_cnt <= '0;
               end
            end
            fill_s: begin
               fill_cnt <= fill_cnt + 1'b1;
               if (mem_rd) accu <= accu + mp_base;
            end
            ready_s: begin
               if (swap) begin
                  sh_base <= sh_accu_base;
                  sh_frac <= '0;
                  sh_cnt  <= '0;
               end
            end
            shift_s: begin
               sh_frac <= sh_sum[FRAC_W-1:0];
               sh_cnt  <= sh_cnt + 1'b1;
               if (sh_step) begin
                  for (int i = 0; i < BUF_DEPTH - 1; i++) line_buf[i] <= line_buf[i+1];
                  line_buf[BUF_DEPTH-1] <= '0;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef NABP_SWAPPABLE_PROTO_CHECK_EN
   logic ignored_evt;

   always_comb begin
      ignored_evt = (swap && state != ready_s)
                 || (next_itr_ack && state != idle_s && state != done_s)
                 || (swap && next_itr_ack);
   end

   always_ff @(posedge clk) begin
      if (!reset_n)         proto_err <= 1'b0;
      else if (ignored_evt) proto_err <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_nabp_swappable.sv
// tb/tb_nabp_swappable.sv - directed plus randomized bench for nabp_swappable with a behavioural model.
module tb_nabp_swappable;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [13:0] mp_accu_init;
   logic [13:0] mp_accu_base;
   logic [4:0]  sh_accu_base;
   logic        swap;
   logic        next_itr_ack;
   logic        swap_ready;
   logic        next_itr;
   logic        mem_rd;
   logic [9:0]  mem_addr;
   logic [11:0] mem_data;
   logic        pe_kick;
   logic        pe_en;
   logic [11:0] pe_data;
`ifdef NABP_SWAPPABLE_PROTO_CHECK_EN
   logic        proto_err;
`endif

   int          n_assert = 0;
   int          n_fail = 0;
   int          salt = 100;
   logic        exp_perr = 1'b0;
   logic [11:0] ref_buf [8];

   always #5 clk = ~clk;

   nabp_swappable dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .mp_accu_init (mp_accu_init),
      .mp_accu_base (mp_accu_base),
      .sh_accu_base (sh_accu_base),
      .swap         (swap),
      .next_itr_ack (next_itr_ack),
      .swap_ready   (swap_ready),
      .next_itr     (next_itr),
      .mem_rd       (mem_rd),
      .mem_addr     (mem_addr),
      .mem_data     (mem_data),
      .pe_kick      (pe_kick),
      .pe_en        (pe_en),
      .pe_data      (pe_data)
`ifdef NABP_SWAPPABLE_PROTO_CHECK_EN
      ,
      .proto_err    (proto_err)
`endif
   );

   function automatic logic [11:0] mem_f(input logic [9:0] a);
      return 12'(32'(a) + salt);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_perr(input string tag);
`ifdef NABP_SWAPPABLE_PROTO_CHECK_EN
      chk(tag, 32'(proto_err), 32'(exp_perr));
`endif
   endtask

   // Memory answers exactly one cycle after the strobe; junk otherwise.
   task automatic cyc();
      logic       rd;
      logic [9:0] a;
      rd = mem_rd;
      a  = mem_addr;
      @(posedge clk);
      #1;
      mem_data = rd ? mem_f(a) : 12'($urandom);
      @(negedge clk);
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_swap_ready"}, 32'(swap_ready), 0);
      chk({tag, "_next_itr"},   32'(next_itr), 0);
      chk({tag, "_mem_rd"},     32'(mem_rd), 0);
      chk({tag, "_mem_addr"},   32'(mem_addr), 0);
      chk({tag, "_pe_kick"},    32'(pe_kick), 0);
      chk({tag, "_pe_en"},      32'(pe_en), 0);
      chk({tag, "_pe_data"},    32'(pe_data), 0);
      chk_perr({tag, "_proto_err"});
   endtask

   task automatic do_fill(input logic [13:0] init, input logic [13:0] base,
                          input int swap_at, input int ack_at);
      logic [13:0] acc;
      mp_accu_init = init;
      mp_accu_base = base;
      next_itr_ack = 1'b1;
      cyc();
      next_itr_ack = 1'b0;
      mp_accu_init = 14'($urandom);
      mp_accu_base = 14'($urandom);
      chk("next_itr_drop", 32'(next_itr), 0);
      for (int k = 0; k <= 8; k++) begin
         acc = 14'(32'(init) + k * 32'(base));
         if (k < 8) begin
            chk("fill_rd", 32'(mem_rd), 1);
            chk("fill_addr", 32'(mem_addr), 32'(acc[13:4]));
            ref_buf[k] = mem_f(acc[13:4]);
         end else begin
            chk("fill_rd_end", 32'(mem_rd), 0);
         end
         chk("fill_not_ready", 32'(swap_ready), 0);
         if (k == swap_at) swap = 1'b1;
         if (k == ack_at) next_itr_ack = 1'b1;
         cyc();
         swap = 1'b0;
         next_itr_ack = 1'b0;
         if (k == swap_at || k == ack_at) exp_perr = 1'b1;
         chk_perr("fill_proto_err");
      end
      chk("swap_ready_rise", 32'(swap_ready), 1);
   endtask

   task automatic do_shift(input logic [4:0] sb, input int hold, input int rst_at);
      int          steps;
      logic [11:0] exp_d;
      repeat (2) begin
         cyc();
         chk("ready_hold", 32'(swap_ready), 1);
      end
      sh_accu_base = sb;
      swap = 1'b1;
      cyc();
      swap = 1'b0;
      sh_accu_base = 5'($urandom);
      chk("swap_ready_drop", 32'(swap_ready), 0);
      for (int k = 0; k < 16; k++) begin
         if (k == rst_at) begin
            reset_n = 1'b0;
            cyc();
            reset_n = 1'b1;
            exp_perr = 1'b0;
            check_idle("rst_mid");
            cyc();
            check_idle("rst_after");
            return;
         end
         steps = (sb >= 5'd16) ? k : (k * int'(sb)) / 16;
         exp_d = (steps < 8) ? ref_buf[steps] : 12'd0;
         chk("shift_pe_en", 32'(pe_en), 1);
         chk("shift_pe_kick", 32'(pe_kick), (k == 0) ? 1 : 0);
         chk("shift_pe_data", 32'(pe_data), 32'(exp_d));
         chk("shift_next_itr", 32'(next_itr), 0);
         cyc();
      end
      chk("post_pe_en", 32'(pe_en), 0);
      chk("post_pe_kick", 32'(pe_kick), 0);
      chk("next_itr_rise", 32'(next_itr), 1);
      repeat (hold) begin
         cyc();
         chk("next_itr_hold", 32'(next_itr), 1);
         chk("done_no_rd", 32'(mem_rd), 0);
      end
   endtask

   initial begin
      reset_n      = 1'b0;
      swap         = 1'b0;
      next_itr_ack = 1'b0;
      mp_accu_init = '0;
      mp_accu_base = '0;
      sh_accu_base = '0;
      mem_data     = '0;
      @(negedge clk);
      repeat (3) cyc();
      check_idle("reset");
      reset_n = 1'b1;
      cyc();
      check_idle("idle");

      salt = 100;
      do_fill(14'h020, 14'h018, -1, -1);
      do_shift(5'h10, 10, -1);

      do_fill(14'h020, 14'h018, 2, 3);
      do_shift(5'h08, 3, -1);

      salt = 7;
      do_fill(14'h3ff0, 14'h0123, -1, -1);
      do_shift(5'h0c, 0, 5);

      for (int r = 0; r < 6; r++) begin
         salt = int'($urandom_range(0, 4095));
         do_fill(14'($urandom), 14'($urandom), -1, -1);
         do_shift(5'($urandom), int'($urandom_range(0, 4)), -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
